// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register target.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RACK,
    ST_IGNORE
  } i2c_tgt_state_t;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  // Position of the R/W flag inside the received address byte.
  localparam int unsigned I2C_RW_BIT = 0;

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchronizer plus run-length glitch filter for one open-drain line.
module i2c_line_filter #(
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic pad,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam logic [3:0] CNT_MAX = 4'(FILTER_LEN - 1);

  logic       sync1;
  logic       sync2;
  logic [3:0] cnt;

  // Idle bus level is high, so everything resets to 1 to avoid a false edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync1 <= pad;
      sync2 <= sync1;
      rise  <= 1'b0;
      fall  <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        level <= sync2;
        rise  <= sync2;
        fall  <= ~sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target exposing a 256-byte register space through a pointer/strobe port.
module i2c_target_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0]  TARGET_ADDR = 7'h50,
  parameter int unsigned FILTER_LEN  = 3
) (
  input  logic           clk_clk,
  input  logic           reset_reset,
  input  logic           i2c_serial_sda_in,
  input  logic           i2c_serial_scl_in,
  output logic           i2c_serial_sda_oe,
  output logic           i2c_serial_scl_oe,
  output logic [7:0]     reg_addr,
  output logic [7:0]     reg_wdata,
  output logic           reg_wr,
  output logic           reg_rd,
  input  logic [7:0]     reg_rdata,
  output logic           busy,
  output i2c_tgt_state_t dbg_state
);

  logic sda_f, sda_rise, sda_fall;
  logic scl_f, scl_rise, scl_fall;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
    .clk(clk_clk), .rst(reset_reset), .pad(i2c_serial_sda_in),
    .level(sda_f), .rise(sda_rise), .fall(sda_fall)
  );

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
    .clk(clk_clk), .rst(reset_reset), .pad(i2c_serial_scl_in),
    .level(scl_f), .rise(scl_rise), .fall(scl_fall)
  );

  logic start_det, stop_det;
  assign start_det = sda_fall & scl_f;
  assign stop_det  = sda_rise & scl_f;

  i2c_tgt_state_t state_q, state_d;
  logic [3:0] bit_cnt;
  logic [7:0] sr;
  logic       sda_q, rw_q, rd_q, rd_pend, busy_q;

  logic       byte_done, addr_match;
  logic [7:0] sr_next;
  logic [2:0] rd_idx;
  assign byte_done  = (bit_cnt == 4'd8);
  assign addr_match = (sr[7:1] == TARGET_ADDR);
  assign sr_next    = {sr[6:0], sda_f};
  assign rd_idx     = 3'd7 - bit_cnt[2:0];

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) state_q <= ST_IDLE;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (stop_det) begin
      state_d = ST_IDLE;
    end else if (start_det) begin
      state_d = ST_ADDR;
    end else begin
      case (state_q)
        ST_ADDR:      if (scl_fall && byte_done) state_d = addr_match ? ST_ADDR_ACK : ST_IGNORE;
        ST_ADDR_ACK:  if (scl_fall) state_d = rw_q ? ST_RDATA : ST_PTR;
        ST_PTR:       if (scl_fall && byte_done) state_d = ST_PTR_ACK;
        ST_PTR_ACK:   if (scl_fall) state_d = ST_WDATA;
        ST_WDATA:     if (scl_fall && byte_done) state_d = ST_WDATA_ACK;
        ST_WDATA_ACK: if (scl_fall) state_d = ST_WDATA;
        ST_RDATA:     if (scl_fall && byte_done) state_d = ST_RACK;
        ST_RACK:      if (scl_rise) state_d = (sda_f == I2C_ACK) ? ST_RDATA : ST_IGNORE;
        default:      state_d = state_q;
      endcase
    end
  end

  // Register port: reg_wr and reg_rd are single-cycle strobes qualified by
  // reg_addr; local logic must present reg_rdata in the cycle after reg_rd,
  // where it is captured. There is no back-pressure on either strobe.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      bit_cnt   <= '0;
      sr        <= '0;
      sda_q     <= 1'b0;
      rw_q      <= 1'b0;
      rd_q      <= 1'b0;
      rd_pend   <= 1'b0;
      busy_q    <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_wr    <= 1'b0;
      reg_rd    <= 1'b0;
    end else begin
      reg_wr  <= 1'b0;
      reg_rd  <= rd_pend;
      rd_pend <= 1'b0;
      rd_q    <= reg_rd;
      if (reg_wr) reg_addr <= reg_addr + 8'd1;
      if (rd_q)   sr <= reg_rdata;
      if (start_det || stop_det) begin
        bit_cnt <= '0;
        sda_q   <= 1'b0;
        rd_pend <= 1'b0;
        if (stop_det) busy_q <= 1'b0;
      end else begin
        case (state_q)
          ST_ADDR, ST_PTR, ST_WDATA: begin
            if (scl_rise && !byte_done) begin
              sr      <= sr_next;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7 && state_q == ST_PTR) reg_addr <= sr_next;
              if (bit_cnt == 4'd7 && state_q == ST_WDATA) begin
                reg_wr    <= 1'b1;
                reg_wdata <= sr_next;
              end
            end
            if (scl_fall && byte_done) begin
              if (state_q != ST_ADDR || addr_match) sda_q <= 1'b1;
              if (state_q == ST_ADDR) begin
                busy_q <= addr_match;
                if (addr_match) begin
                  rw_q   <= sr[I2C_RW_BIT];
                  reg_rd <= sr[I2C_RW_BIT];
                end
              end
            end
          end
          ST_ADDR_ACK: if (scl_fall) begin
            bit_cnt <= '0;
            sda_q   <= rw_q ? ~sr[7] : 1'b0;
          end
          ST_PTR_ACK, ST_WDATA_ACK: if (scl_fall) begin
            bit_cnt <= '0;
            sda_q   <= 1'b0;
          end
          ST_RDATA: begin
            if (scl_rise && !byte_done) bit_cnt <= bit_cnt + 4'd1;
            if (scl_fall) sda_q <= byte_done ? 1'b0 : ~sr[rd_idx];
          end
          ST_RACK: if (scl_rise) begin
            if (sda_f == I2C_ACK) begin
              reg_addr <= reg_addr + 8'd1;
              rd_pend  <= 1'b1;
              bit_cnt  <= '0;
            end else begin
              busy_q <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // The START/STOP gate lets SDA go in the very cycle the condition is seen.
  assign i2c_serial_sda_oe = sda_q & ~(start_det | stop_det);
  assign i2c_serial_scl_oe = 1'b0;
  assign busy              = busy_q;
  assign dbg_state         = state_q;

endmodule
